keypad_control: RTL and testbench
=================================

// Module: keypad_control
// PURPOSE
//  Consumer end of the keypad scan path: takes kphit/buttonNum from the keypad decoder, synchronises
//  and debounces them, and turns each press into exactly one command.
//  Commands update freqSelect (sine generator), lowpassSelect and highpassSelect (filter stages).
//  Also generates the free-running 7-seg digit scan index for the display mux/digit decoder.
// PARAMETERS
//  DEBOUNCE_CYCLES  480  consecutive stable synced samples required for press and for release (>=2)
//  SCAN_DIV         48   clk_48 cycles each display digit is held before advancing (>=1)
// PORTS
//  clk_48          in   1  sole clock; all state on rising edge
//  reset_n         in   1  asynchronous, active-low reset
//  kphit           in   1  key-down flag from keypad decoder; asynchronous to clk_48, may bounce
//  buttonNum       in   4  key code 0x0-0xF, valid only while kphit=1
//  freqSelect      out  3  sine frequency select
//  lowpassSelect   out  3  lowpass filter select
//  highpassSelect  out  3  highpass filter select
//  cmd_strobe      out  1  1-cycle pulse when a debounced press is accepted
//  cmd_code        out  4  key code of last accepted press; holds between strobes
//  digit           out  2  display digit scan index
// BEHAVIOUR
//  Reset (async assert, sync-free release): all outputs 0, FSM=IDLE, counters 0, sync flops 0.
//   Reset mid-press discards the pending press; no strobe is emitted for it.
//  Sync: kphit and buttonNum each pass through 2 flops (ks, bs) before any use.
//  FSM (registered state, counter cnt):
//   IDLE: ks=1 -> capture key=bs, cnt=1, go ARM.
//   ARM: ks=0 -> IDLE. bs!=key -> key=bs, cnt=1 (restart). else cnt++.
//    When cnt reaches DEBOUNCE_CYCLES -> go HELD; on the same edge pulse cmd_strobe, set cmd_code=key,
//    and apply the command.
//   HELD: ks=0 -> cnt=1, go RELEASE. Key changes while held are ignored (no new command).
//   RELEASE: ks=1 -> HELD (glitch, no new strobe). ks=0 -> cnt++; cnt reaches DEBOUNCE_CYCLES -> IDLE.
//  Latency: cmd_strobe rises DEBOUNCE_CYCLES+2 edges after the first edge sampling a clean kphit=1.
//   Select outputs change on the same edge as the strobe.
//   One press yields exactly one strobe regardless of hold time.
//  Command map (key -> action); selects are 3-bit unsigned:
//   0x0: freq, lowpass and highpass selects all set to 0.
//   0x1-0x7: freqSelect=key[2:0].
//   0x8, 0x9: no select change; strobe and cmd_code still update.
//   0xA: freqSelect+1, wraps 7->0.   0xB: freqSelect-1, wraps 0->7.
//   0xC: lowpassSelect+1, saturates at 7.   0xD: lowpassSelect-1, saturates at 0.
//   0xE: highpassSelect+1, saturates at 7.  0xF: highpassSelect-1, saturates at 0.
//  Digit scan: divider counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and digit increments.
//   digit wraps 3->0. Scan is independent of the keypad FSM.
//   With SCAN_DIV=1, digit advances every cycle.
//  No combinational path from inputs to outputs.
// TESTING (DEBOUNCE_CYCLES=4, SCAN_DIV=3 unless noted)
//  1 Reset: hold reset_n=0, toggle kphit -> all outputs 0; release -> digit 0,1,2,3,0 every 3 cycles.
//  2 Clean press 0x5, held 20 cycles, then released -> single cmd_strobe at edge 6, freqSelect=5,
//    cmd_code=5; no further strobe.
//  3 Bounce: kphit 1,0,1,0 each 1 cycle, then stable high with key 0xC -> exactly one strobe,
//    lowpassSelect 0->1; code changes mid-ARM restart the count.
//  4 Wrap/saturate: from reset press 0xB -> freqSelect=7; press 0xD -> lowpassSelect stays 0;
//    press 0xE eight times -> highpassSelect=7.
//  5 Release glitch: held key 0xA, kphit low 2 cycles then high -> no second strobe;
//    later full release then press 0xA -> freqSelect increments again.
//  6 Reset mid-ARM: key 0x3 held 2 synced cycles, reset_n pulse -> no strobe, freqSelect=0.
//    Hold 0x3 through reset release -> strobe 6 edges after release.

Source files
------------

// File: rtl/keypad_control.sv
// keypad_control: consumer end of the keypad scan path.
// Synchronises and debounces kphit/buttonNum and turns each press into one command
// that updates the sine frequency and filter selects. Also runs the 7-seg digit scan.
module keypad_control #(
  parameter int DEBOUNCE_CYCLES = 480,
  parameter int SCAN_DIV        = 48
) (
  input  logic       clk_48,
  input  logic       reset_n,
  input  logic       kphit,
  input  logic [3:0] buttonNum,
  output logic [2:0] freqSelect,
  output logic [2:0] lowpassSelect,
  output logic [2:0] highpassSelect,
  output logic       cmd_strobe,
  output logic [3:0] cmd_code,
  output logic [1:0] digit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       key;

  logic             kphit_p0;
  logic             ks;
  logic [3:0]       bnum_p0;
  logic [3:0]       bs;

  logic [DIV_W-1:0] div;

  // Saturating increment of a 3-bit select (sticks at 7).
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Saturating decrement of a 3-bit select (sticks at 0).
  function automatic logic [2:0] sat_dec3(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  // Two-flop synchroniser for the asynchronous key flag and key code.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      kphit_p0 <= 1'b0;
      ks       <= 1'b0;
      bnum_p0  <= 4'h0;
      bs       <= 4'h0;
    end else begin
      kphit_p0 <= kphit;
      ks       <= kphit_p0;
      bnum_p0  <= buttonNum;
      bs       <= bnum_p0;
    end
  end

  // Debounce FSM: one accepted press produces one strobe and one select update.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      key            <= 4'h0;
      cmd_strobe     <= 1'b0;
      cmd_code       <= 4'h0;
      freqSelect     <= 3'd0;
      lowpassSelect  <= 3'd0;
      highpassSelect <= 3'd0;
    end else begin
      cmd_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (ks) begin
            key   <= bs;
            cnt   <= CNT_ONE;
            state <= ARM;
          end
        end
        ARM: begin
          if (!ks) begin
            state <= IDLE;
          end else if (bs != key) begin
            // Code still settling: restart the stability count on the new code.
            key <= bs;
            cnt <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            cnt        <= cnt + CNT_ONE;
            state      <= HELD;
            cmd_strobe <= 1'b1;
            cmd_code   <= key;
            case (key)
              4'h0: begin
                freqSelect     <= 3'd0;
                lowpassSelect  <= 3'd0;
                highpassSelect <= 3'd0;
              end
              4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: freqSelect <= key[2:0];
              4'hA: freqSelect     <= freqSelect + 3'd1;
              4'hB: freqSelect     <= freqSelect - 3'd1;
              4'hC: lowpassSelect  <= sat_inc3(lowpassSelect);
              4'hD: lowpassSelect  <= sat_dec3(lowpassSelect);
              4'hE: highpassSelect <= sat_inc3(highpassSelect);
              4'hF: highpassSelect <= sat_dec3(highpassSelect);
              default: ; // 0x8, 0x9: strobe and code only
            endcase
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          // Code changes while held are deliberately ignored.
          if (!ks) begin
            cnt   <= CNT_ONE;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (ks) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scan: hold each digit SCAN_DIV cycles, then advance.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      div   <= '0;
      digit <= 2'd0;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      digit <= digit + 2'd1;
    end else begin
      div <= div + DIV_ONE;
    end
  end

endmodule

// File: tb/tb_keypad_control.sv
// Testbench for keypad_control: directed presses with hand-computed expected commands
// queued on a scoreboard; a negedge monitor pops and compares on every cmd_strobe.
module tb_keypad_control;

  logic       clk_48 = 1'b0;
  logic       reset_n;
  logic       kphit;
  logic [3:0] buttonNum;
  logic [2:0] freqSelect, lowpassSelect, highpassSelect;
  logic       cmd_strobe;
  logic [3:0] cmd_code;
  logic [1:0] digit;

  logic [2:0] freq_1, lp_1, hp_1;
  logic       strobe_1;
  logic [3:0] code_1;
  logic [1:0] digit_1;

  keypad_control #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(3)) dut (
    .clk_48(clk_48), .reset_n(reset_n), .kphit(kphit), .buttonNum(buttonNum),
    .freqSelect(freqSelect), .lowpassSelect(lowpassSelect), .highpassSelect(highpassSelect),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .digit(digit)
  );

  keypad_control #(.DEBOUNCE_CYCLES(2), .SCAN_DIV(1)) dut_div1 (
    .clk_48(clk_48), .reset_n(reset_n), .kphit(kphit), .buttonNum(buttonNum),
    .freqSelect(freq_1), .lowpassSelect(lp_1), .highpassSelect(hp_1),
    .cmd_strobe(strobe_1), .cmd_code(code_1), .digit(digit_1)
  );

  always #5 clk_48 = ~clk_48;

  int edge_cnt = 0;
  always @(posedge clk_48) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [3:0] code;
    logic [2:0] f;
    logic [2:0] lp;
    logic [2:0] hp;
    int         edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  task automatic expect_cmd(input logic [3:0] code, input logic [2:0] f,
                            input logic [2:0] lp, input logic [2:0] hp, input int edge_n);
    exp_t e;
    e.code = code; e.f = f; e.lp = lp; e.hp = hp; e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  // Clean press from IDLE: strobe expected on the 6th edge after kphit is driven.
  task automatic press(input logic [3:0] key, input logic [2:0] f,
                       input logic [2:0] lp, input logic [2:0] hp, input int hold);
    expect_cmd(key, f, lp, hp, edge_cnt + 6);
    buttonNum = key;
    kphit     = 1'b1;
    tick(hold);
    kphit = 1'b0;
    tick(10);
  endtask

  // Scoreboard monitor.
  always @(negedge clk_48) begin
    if (cmd_strobe === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: strobe with code %0d, expected none (t=%0t)", cmd_code, $time);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_code", int'(cmd_code), int'(mon_e.code));
        check("strobe_freq", int'(freqSelect), int'(mon_e.f));
        check("strobe_lowpass", int'(lowpassSelect), int'(mon_e.lp));
        check("strobe_highpass", int'(highpassSelect), int'(mon_e.hp));
        check("strobe_edge", edge_cnt, mon_e.edge_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    kphit     = 1'b0;
    buttonNum = 4'h0;
    @(negedge clk_48);

    // 1: reset holds everything at zero despite input activity
    for (int i = 0; i < 6; i++) begin
      kphit     = ~kphit;
      buttonNum = 4'(i + 5);
      tick(1);
      check("rst_freq", int'(freqSelect), 0);
      check("rst_lowpass", int'(lowpassSelect), 0);
      check("rst_highpass", int'(highpassSelect), 0);
      check("rst_strobe", int'(cmd_strobe), 0);
      check("rst_code", int'(cmd_code), 0);
      check("rst_digit", int'(digit), 0);
    end
    kphit     = 1'b0;
    buttonNum = 4'h0;
    reset_n   = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      check("scan_digit", int'(digit), (k / 3) % 4);
      check("scan_digit_div1", int'(digit_1), k % 4);
      tick(1);
    end

    // 2: clean press 0x5, long hold, one strobe
    press(4'h5, 3'd5, 3'd0, 3'd0, 20);
    check("code_holds", int'(cmd_code), 5);
    check("freq_after_5", int'(freqSelect), 5);

    // 3: bounce, then code settling 0x9 -> 0xC during ARM
    buttonNum = 4'hC;
    kphit = 1'b1; tick(1);
    kphit = 1'b0; tick(1);
    kphit = 1'b1; tick(1);
    kphit = 1'b0; tick(1);
    expect_cmd(4'hC, 3'd5, 3'd1, 3'd0, edge_cnt + 8);
    buttonNum = 4'h9;
    kphit     = 1'b1;
    tick(2);
    buttonNum = 4'hC;
    tick(15);
    kphit = 1'b0;
    tick(10);
    check("lowpass_after_C", int'(lowpassSelect), 1);

    // 4: wrap and saturation from reset
    reset_n = 1'b0;
    tick(1);
    check("rst2_freq", int'(freqSelect), 0);
    check("rst2_lowpass", int'(lowpassSelect), 0);
    reset_n = 1'b1;
    tick(2);
    press(4'hB, 3'd7, 3'd0, 3'd0, 10);
    press(4'hD, 3'd7, 3'd0, 3'd0, 10);
    for (int i = 1; i <= 8; i++)
      press(4'hE, 3'd7, 3'd0, (i < 7) ? 3'(i) : 3'd7, 10);
    check("highpass_sat", int'(highpassSelect), 7);

    // 5: release glitch yields no second strobe; freq wraps 7 -> 0 then 0 -> 1
    expect_cmd(4'hA, 3'd0, 3'd0, 3'd7, edge_cnt + 6);
    buttonNum = 4'hA;
    kphit     = 1'b1;
    tick(10);
    kphit = 1'b0;
    tick(2);
    kphit = 1'b1;
    tick(10);
    kphit = 1'b0;
    tick(10);
    check("freq_after_glitch", int'(freqSelect), 0);
    press(4'hA, 3'd1, 3'd0, 3'd7, 10);

    // 6: reset during ARM discards the press; holding through release re-arms
    buttonNum = 4'h3;
    kphit     = 1'b1;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    check("rst3_freq", int'(freqSelect), 0);
    check("rst3_highpass", int'(highpassSelect), 0);
    check("rst3_code", int'(cmd_code), 0);
    expect_cmd(4'h3, 3'd3, 3'd0, 3'd0, edge_cnt + 6);
    reset_n = 1'b1;
    tick(12);
    kphit = 1'b0;
    tick(10);
    check("freq_after_3", int'(freqSelect), 3);

    tick(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
